// File: rtl/iter_cipher_pkg.sv
// iter_cipher_pkg
// Shared types and helpers for the iterative cipher core:
//   state_e        - control FSM encoding
//   NR_MIN/NR_MAX  - legal round-count range; DATA_W_MIN - smallest legal width
//   rotl/rotr      - rotates over a runtime-constant width w (w <= MAX_W)
//   rc             - round constant, XORed into bits [7:0] of the round key
// Optional feature macro: ITER_CIPHER_DECRYPT_EN (used by the importers).
package iter_cipher_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    KEYEXP = 3'd1,
    ROUND  = 3'd2,
    DONE   = 3'd3,
    WIPE   = 3'd4
  } state_e;

  localparam int NR_MIN     = 1;
  localparam int NR_MAX     = 15;
  localparam int DATA_W_MIN = 16;

  // Rotates work on a MAX_W container so one function serves every DATA_W;
  // bits at and above w are returned as 0. With constant w and n these
  // reduce to plain wiring.
  localparam int MAX_W = 512;
  localparam int IDX_W = $clog2(MAX_W);

  function automatic logic [MAX_W-1:0] rotl(input logic [MAX_W-1:0] x,
                                            input int w, input int n);
    logic [MAX_W-1:0] r;
    r = '0;
    for (int b = 0; b < MAX_W; b++)
      if (b < w) r[IDX_W'(b)] = x[IDX_W'((b + w - n) % w)];
    return r;
  endfunction

  function automatic logic [MAX_W-1:0] rotr(input logic [MAX_W-1:0] x,
                                            input int w, input int n);
    logic [MAX_W-1:0] r;
    r = '0;
    for (int b = 0; b < MAX_W; b++)
      if (b < w) r[IDX_W'(b)] = x[IDX_W'((b + n) % w)];
    return r;
  endfunction

  // Round constant for round i is simply the byte value i.
  function automatic logic [7:0] rc(input logic [7:0] i);
    return i;
  endfunction

endpackage

// File: rtl/iter_cipher_if.sv
// iter_cipher_if
// Request/result handshake bundle for iter_cipher_core.
//   in_valid/in_ready/in_key/in_data[/in_mode] - request side
//   abort                                      - kill and wipe current op
//   out_valid/out_ready/out_data               - result side
//   busy                                       - core not idle
// master = producer/consumer side, slave = the core.
// in_mode exists only when ITER_CIPHER_DECRYPT_EN is defined.
interface iter_cipher_if #(parameter int DATA_W = 128);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_key;
  logic [DATA_W-1:0] in_data;
`ifdef ITER_CIPHER_DECRYPT_EN
  logic              in_mode;
`endif
  logic              abort;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              busy;

`ifdef ITER_CIPHER_DECRYPT_EN
  modport master (output in_valid, in_key, in_data, in_mode, abort, out_ready,
                  input  in_ready, out_valid, out_data, busy);
  modport slave  (input  in_valid, in_key, in_data, in_mode, abort, out_ready,
                  output in_ready, out_valid, out_data, busy);
`else
  modport master (output in_valid, in_key, in_data, abort, out_ready,
                  input  in_ready, out_valid, out_data, busy);
  modport slave  (input  in_valid, in_key, in_data, abort, out_ready,
                  output in_ready, out_valid, out_data, busy);
`endif
endinterface

// File: rtl/iter_cipher_round.sv
// iter_cipher_round
// Combinational single round plus key step.
//   s, rk    - current state / round key
//   i        - round index fed to the round constant
//   mode     - 0 forward, 1 inverse (only with ITER_CIPHER_DECRYPT_EN)
//   s_next   - next state
//   rk_next  - next round key (forward: rk(i); inverse: rk(i-1))
// The forward key step alone is also what KEYEXP uses to walk to rk(NR).
module iter_cipher_round
  import iter_cipher_pkg::*;
#(
  parameter int DATA_W = 128
) (
  input  logic [DATA_W-1:0] s,
  input  logic [DATA_W-1:0] rk,
  input  logic [7:0]        i,
`ifdef ITER_CIPHER_DECRYPT_EN
  input  logic              mode,
`endif
  output logic [DATA_W-1:0] s_next,
  output logic [DATA_W-1:0] rk_next
);

  logic [DATA_W-1:0] rc_w;
  logic [DATA_W-1:0] rk_fwd;
  logic [DATA_W-1:0] s_fwd;

  assign rc_w   = {{(DATA_W-8){1'b0}}, rc(i)};
  // Forward: rk(i) = rotl(rk(i-1),8) ^ RC(i); s(i) = rotl(s(i-1) ^ rk(i), 1)
  assign rk_fwd = DATA_W'(rotl(MAX_W'(rk), DATA_W, 8)) ^ rc_w;
  assign s_fwd  = DATA_W'(rotl(MAX_W'(s ^ rk_fwd), DATA_W, 1));

`ifdef ITER_CIPHER_DECRYPT_EN
  logic [DATA_W-1:0] rk_inv;
  logic [DATA_W-1:0] s_inv;

  // Inverse: s = rotr(s,1) ^ rk(i); rk(i-1) = rotr(rk(i) ^ RC(i), 8)
  assign s_inv   = DATA_W'(rotr(MAX_W'(s), DATA_W, 1)) ^ rk;
  assign rk_inv  = DATA_W'(rotr(MAX_W'(rk ^ rc_w), DATA_W, 8));
  assign s_next  = mode ? s_inv  : s_fwd;
  assign rk_next = mode ? rk_inv : rk_fwd;
`else
  assign s_next  = s_fwd;
  assign rk_next = rk_fwd;
`endif

endmodule

// File: rtl/iter_cipher_core.sv
// iter_cipher_core
// Iterative block cipher, one round per clock, with zeroization.
//   clk, rst   - clock; synchronous active-high reset
//   bus        - iter_cipher_if.slave: request handshake, abort, result
//                handshake, busy
// Parameters: DATA_W (multiple of 8, >= 16, <= MAX_W), NR (1..15).
// Optional feature: ITER_CIPHER_DECRYPT_EN adds in_mode, the KEYEXP state and
// the inverse datapath; without it the core is encrypt only.
// State, key and counter registers are cleared on reset, abort, the result
// handshake and in WIPE, so key material never outlives an operation.
module iter_cipher_core
  import iter_cipher_pkg::*;
#(
  parameter int DATA_W = 128,
  parameter int NR     = 10
) (
  input  logic         clk,
  input  logic         rst,
  iter_cipher_if.slave bus
);

  localparam int            CW   = $clog2(NR + 1);
  localparam logic [CW-1:0] LAST = CW'(NR - 1);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] s_q, s_d;
  logic [DATA_W-1:0] rk_q, rk_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [7:0]        rnd_i;
  logic [DATA_W-1:0] s_nx, rk_nx;

`ifdef ITER_CIPHER_DECRYPT_EN
  logic mode_q, mode_d;
  logic rnd_mode;

  // Inverse datapath only while decrypting in ROUND; KEYEXP walks forward.
  assign rnd_mode = (state_q == ROUND) && mode_q;
  // Decrypt rounds count i down from NR; everything else counts up from 1.
  assign rnd_i    = rnd_mode ? (8'(NR) - 8'(cnt_q)) : (8'(cnt_q) + 8'd1);
`else
  assign rnd_i    = 8'(cnt_q) + 8'd1;
`endif

  iter_cipher_round #(.DATA_W(DATA_W)) u_round (
    .s       (s_q),
    .rk      (rk_q),
    .i       (rnd_i),
`ifdef ITER_CIPHER_DECRYPT_EN
    .mode    (rnd_mode),
`endif
    .s_next  (s_nx),
    .rk_next (rk_nx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      s_q     <= '0;
      rk_q    <= '0;
      cnt_q   <= '0;
`ifdef ITER_CIPHER_DECRYPT_EN
      mode_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      rk_q    <= rk_d;
      cnt_q   <= cnt_d;
`ifdef ITER_CIPHER_DECRYPT_EN
      mode_q  <= mode_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    rk_d    = rk_q;
    cnt_d   = cnt_q;
`ifdef ITER_CIPHER_DECRYPT_EN
    mode_d  = mode_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          rk_d  = bus.in_key;
          cnt_d = '0;
`ifdef ITER_CIPHER_DECRYPT_EN
          mode_d = bus.in_mode;
          if (bus.in_mode) begin
            // Decrypt needs rk(NR) first; key is whitened only at the end.
            s_d     = bus.in_data;
            state_d = KEYEXP;
          end else begin
            s_d     = bus.in_data ^ bus.in_key;
            state_d = ROUND;
          end
`else
          s_d     = bus.in_data ^ bus.in_key;
          state_d = ROUND;
`endif
        end
      end

`ifdef ITER_CIPHER_DECRYPT_EN
      KEYEXP: begin
        rk_d  = rk_nx;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = ROUND;
        end
      end
`endif

      ROUND: begin
        s_d   = s_nx;
        rk_d  = rk_nx;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = DONE;
`ifdef ITER_CIPHER_DECRYPT_EN
          // Last inverse step has just produced rk0: fold the whitening in.
          if (mode_q) s_d = s_nx ^ rk_nx;
`endif
        end
      end

      DONE: begin
        if (bus.out_ready) begin
          // Result is consumed on this edge; nothing left worth keeping.
          s_d     = '0;
          rk_d    = '0;
          cnt_d   = '0;
          state_d = WIPE;
        end
      end

      WIPE: begin
        s_d     = '0;
        rk_d    = '0;
        cnt_d   = '0;
        state_d = IDLE;
      end

      default: begin
        s_d     = '0;
        rk_d    = '0;
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase

    // Abort wins over everything, including a result handshake.
    if (bus.abort && (state_q != IDLE)) begin
      s_d     = '0;
      rk_d    = '0;
      cnt_d   = '0;
      state_d = IDLE;
    end

`ifdef ITER_CIPHER_DECRYPT_EN
    if (state_d == IDLE) mode_d = 1'b0;
`endif
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_data  = (state_q == DONE) ? s_q : '0;

endmodule

// File: tb/tb_iter_cipher_core.sv
// tb_iter_cipher_core
// Directed bench for iter_cipher_core: three instances (16-bit NR=1,
// 16-bit NR=2, 128-bit NR=10) driven through a linear sequence of steps.
// Decrypt steps are built only with ITER_CIPHER_DECRYPT_EN.
module tb_iter_cipher_core;
  import iter_cipher_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  iter_cipher_if #(.DATA_W(16))  b1 ();
  iter_cipher_if #(.DATA_W(16))  b2 ();
  iter_cipher_if #(.DATA_W(128)) b3 ();

  iter_cipher_core #(.DATA_W(16),  .NR(1))  d1 (.clk(clk), .rst(rst), .bus(b1));
  iter_cipher_core #(.DATA_W(16),  .NR(2))  d2 (.clk(clk), .rst(rst), .bus(b2));
  iter_cipher_core #(.DATA_W(128), .NR(10)) d3 (.clk(clk), .rst(rst), .bus(b3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference encrypt for 128-bit blocks, straight from the cipher equations.
  function automatic logic [127:0] enc_model(input logic [127:0] k,
                                             input logic [127:0] d,
                                             input int nr);
    logic [127:0] rk;
    logic [127:0] s;
    rk = k;
    s  = d ^ k;
    for (int i = 1; i <= nr; i++) begin
      rk = {rk[119:0], rk[127:120]} ^ 128'(i);
      s  = s ^ rk;
      s  = {s[126:0], s[127]};
    end
    return s;
  endfunction

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  localparam logic [127:0] K = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
  localparam logic [127:0] D = 128'h0123456789abcdefdeadbeefcafef00d;
  localparam logic [127:0] K2 = 128'hffeeddccbbaa99887766554433221100;
  localparam logic [127:0] D2 = 128'h00000000000000000000000000000001;

  logic [127:0] exp_ct;
  logic [127:0] exp_ct2;

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    b1.in_valid = 1'b0; b1.in_key = '0; b1.in_data = '0; b1.abort = 1'b0; b1.out_ready = 1'b0;
    b2.in_valid = 1'b0; b2.in_key = '0; b2.in_data = '0; b2.abort = 1'b0; b2.out_ready = 1'b0;
    b3.in_valid = 1'b0; b3.in_key = '0; b3.in_data = '0; b3.abort = 1'b0; b3.out_ready = 1'b0;
`ifdef ITER_CIPHER_DECRYPT_EN
    b1.in_mode = 1'b0; b2.in_mode = 1'b0; b3.in_mode = 1'b0;
`endif
    exp_ct  = enc_model(K, D, 10);
    exp_ct2 = enc_model(K2, D2, 10);

    // Reset state
    tick(2);
    chk("rst_in_ready1", 128'(b1.in_ready), 128'd1);
    chk("rst_in_ready3", 128'(b3.in_ready), 128'd1);
    chk("rst_out_valid", 128'(b3.out_valid), 128'd0);
    chk("rst_out_data", b3.out_data, 128'd0);
    chk("rst_busy", 128'(b3.busy), 128'd0);
    chk("rst_s", d3.s_q, 128'd0);
    chk("rst_rk", d3.rk_q, 128'd0);
    chk("rst_cnt", 128'(d3.cnt_q), 128'd0);
    rst = 1'b0;
    tick(1);

    // 16-bit NR=1 encrypt of zero: result 0x0002 one cycle after accept
    b1.in_valid = 1'b1;
    tick(1);
    b1.in_valid = 1'b0;
    chk("n1_busy", 128'(b1.busy), 128'd1);
    chk("n1_in_ready_low", 128'(b1.in_ready), 128'd0);
    chk("n1_not_yet", 128'(b1.out_valid), 128'd0);
    tick(1);
    chk("n1_valid", 128'(b1.out_valid), 128'd1);
    chk("n1_data", 128'(b1.out_data), 128'h0002);
    b1.out_ready = 1'b1;
    tick(1);
    b1.out_ready = 1'b0;
    chk("n1_wipe_valid", 128'(b1.out_valid), 128'd0);
    chk("n1_wipe_data", 128'(b1.out_data), 128'd0);
    chk("n1_wipe_in_ready", 128'(b1.in_ready), 128'd0);
    chk("n1_wipe_s", 128'(d1.s_q), 128'd0);
    tick(1);
    chk("n1_idle_in_ready", 128'(b1.in_ready), 128'd1);

    // 16-bit NR=2 encrypt of zero: 0x0200 after two cycles, 0 before
    b2.in_valid = 1'b1;
    tick(1);
    b2.in_valid = 1'b0;
    tick(1);
    chk("n2_mid_valid", 128'(b2.out_valid), 128'd0);
    chk("n2_mid_data", 128'(b2.out_data), 128'd0);
    tick(1);
    chk("n2_valid", 128'(b2.out_valid), 128'd1);
    chk("n2_data", 128'(b2.out_data), 128'h0200);
    b2.out_ready = 1'b1;
    tick(1);
    b2.out_ready = 1'b0;
    tick(1);

    // 128-bit NR=10 encrypt with back-pressure in DONE
    b3.in_key = K; b3.in_data = D; b3.in_valid = 1'b1;
    tick(1);
    b3.in_valid = 1'b0;
    tick(9);
    chk("e10_early", 128'(b3.out_valid), 128'd0);
    tick(1);
    chk("e10_valid", 128'(b3.out_valid), 128'd1);
    chk("e10_data", b3.out_data, exp_ct);
    b3.in_data = ~D; b3.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      chk("stall_valid", 128'(b3.out_valid), 128'd1);
      chk("stall_data", b3.out_data, exp_ct);
      chk("stall_in_ready", 128'(b3.in_ready), 128'd0);
    end
    b3.in_valid = 1'b0;
    b3.out_ready = 1'b1;
    tick(1);
    b3.out_ready = 1'b0;
    chk("e10_hs_s", d3.s_q, 128'd0);
    chk("e10_hs_rk", d3.rk_q, 128'd0);
    chk("e10_hs_in_ready", 128'(b3.in_ready), 128'd0);
    tick(1);
    chk("e10_idle_in_ready", 128'(b3.in_ready), 128'd1);

    // rst pulse while DONE
    b3.in_key = K2; b3.in_data = D2; b3.in_valid = 1'b1;
    tick(1);
    b3.in_valid = 1'b0;
    tick(10);
    chk("rstdone_pre", 128'(b3.out_valid), 128'd1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("rstdone_valid", 128'(b3.out_valid), 128'd0);
    chk("rstdone_data", b3.out_data, 128'd0);
    chk("rstdone_busy", 128'(b3.busy), 128'd0);
    chk("rstdone_in_ready", 128'(b3.in_ready), 128'd1);
    chk("rstdone_rk", d3.rk_q, 128'd0);

    // abort in mid-ROUND
    b3.in_key = K; b3.in_data = D; b3.in_valid = 1'b1;
    tick(1);
    b3.in_valid = 1'b0;
    tick(3);
    b3.abort = 1'b1;
    tick(1);
    b3.abort = 1'b0;
    chk("abort_valid", 128'(b3.out_valid), 128'd0);
    chk("abort_busy", 128'(b3.busy), 128'd0);
    chk("abort_in_ready", 128'(b3.in_ready), 128'd1);
    chk("abort_s", d3.s_q, 128'd0);
    chk("abort_rk", d3.rk_q, 128'd0);
    chk("abort_cnt", 128'(d3.cnt_q), 128'd0);

    // abort in IDLE is ignored: the request is still accepted
    b3.in_key = K2; b3.in_data = D2; b3.in_valid = 1'b1; b3.abort = 1'b1;
    tick(1);
    b3.in_valid = 1'b0; b3.abort = 1'b0;
    chk("idle_abort_busy", 128'(b3.busy), 128'd1);
    tick(10);
    chk("idle_abort_valid", 128'(b3.out_valid), 128'd1);
    chk("idle_abort_data", b3.out_data, exp_ct2);

    // abort together with the result handshake: dropped, straight to IDLE
    b3.abort = 1'b1; b3.out_ready = 1'b1;
    tick(1);
    b3.abort = 1'b0; b3.out_ready = 1'b0;
    chk("abort_hs_in_ready", 128'(b3.in_ready), 128'd1);
    chk("abort_hs_valid", 128'(b3.out_valid), 128'd0);
    chk("abort_hs_s", d3.s_q, 128'd0);
    tick(1);
    chk("abort_hs_still_idle", 128'(b3.busy), 128'd0);

`ifdef ITER_CIPHER_DECRYPT_EN
    // 16-bit NR=1 decrypt of 0x0002 with zero key: 0x0000 after two cycles
    b1.in_key = '0; b1.in_data = 16'h0002; b1.in_mode = 1'b1; b1.in_valid = 1'b1;
    tick(1);
    b1.in_valid = 1'b0; b1.in_mode = 1'b0;
    tick(1);
    chk("d1_early", 128'(b1.out_valid), 128'd0);
    tick(1);
    chk("d1_valid", 128'(b1.out_valid), 128'd1);
    chk("d1_data", 128'(b1.out_data), 128'd0);
    b1.out_ready = 1'b1;
    tick(1);
    b1.out_ready = 1'b0;
    tick(1);

    // 128-bit round trip: decrypting the ciphertext recovers the plaintext
    b3.in_key = K; b3.in_data = exp_ct; b3.in_mode = 1'b1; b3.in_valid = 1'b1;
    tick(1);
    b3.in_valid = 1'b0; b3.in_mode = 1'b0;
    tick(19);
    chk("d10_early", 128'(b3.out_valid), 128'd0);
    tick(1);
    chk("d10_valid", 128'(b3.out_valid), 128'd1);
    chk("d10_data", b3.out_data, D);
    b3.out_ready = 1'b1;
    tick(1);
    b3.out_ready = 1'b0;
    chk("d10_hs_s", d3.s_q, 128'd0);
    chk("d10_hs_rk", d3.rk_q, 128'd0);
    tick(1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
